// File: rtl/reset_sequencer_nch_if.sv
// Sideband bundle between the reset sequencer and the blocks it releases:
// soft-reset/ready requests in, per-channel resets and status out.
interface reset_sequencer_nch_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] soft_reset;
    logic [N_CH-1:0] ch_ready;
    logic [N_CH-1:0] reset_n_out;
    logic            init_done;
    logic            err;
    logic [3:0]      err_ch;
    logic [2:0]      seq_state;

    modport master (
        input  soft_reset, ch_ready,
        output reset_n_out, init_done, err, err_ch, seq_state
    );

    modport slave (
        output soft_reset, ch_ready,
        input  reset_n_out, init_done, err, err_ch, seq_state
    );
endinterface

// File: rtl/reset_sequencer_nch.sv
// Multi-channel reset sequencer: after fabric reset release and a filtered PLL
// lock, releases N_CH resets in index order with delays and ready handshakes.
module reset_sequencer_nch #(
    parameter int unsigned      N_CH          = 4,
    parameter int unsigned      CNT_W         = 16,
    parameter int unsigned      REL_DELAY     = 200,
    parameter int unsigned      LOCK_FILT     = 16,
    parameter int unsigned      READY_TIMEOUT = 1024,
    parameter logic [N_CH-1:0]  READY_MASK    = N_CH'(1)
) (
    input  logic                  clk_base_i,
    input  logic                  power_on_reset_n_i,
    input  logic                  fab_reset_n_i,
    input  logic                  pll_lock_i,
    reset_sequencer_nch_if.master seq_if
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'((REL_DELAY == 0) ? 0 : REL_DELAY - 1);
    localparam logic [CNT_W-1:0] STRETCH_LD = CNT_W'((REL_DELAY == 0) ? 1 : REL_DELAY);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'((LOCK_FILT == 0) ? 0 : LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'((READY_TIMEOUT == 0) ? 0 : READY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_LOCK_WAIT  = 3'd1,
        ST_RELEASE    = 3'd2,
        ST_READY_WAIT = 3'd3,
        ST_DONE       = 3'd4,
        ST_ERROR      = 3'd5
    } state_e;

    logic fab_meta_q, fab_ok_q, lock_meta_q, lock_s_q;

    state_e                       state_q, state_d;
    logic [CH_W-1:0]              ch_q, ch_d;
    logic [CNT_W-1:0]             dly_q, dly_d;
    logic [CNT_W-1:0]             tmo_q, tmo_d;
    logic [CNT_W-1:0]             lock_cnt_q, lock_cnt_d;
    logic [N_CH-1:0]              rst_n_q, rst_n_d;
    logic                         init_done_q, init_done_d;
    logic                         err_q, err_d;
    logic [3:0]                   err_ch_q, err_ch_d;
    logic [N_CH-1:0][CNT_W-1:0]   stretch_q, stretch_d;
    logic                         step_ch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Two-flop synchronisers for the asynchronous fabric reset and lock inputs
    always_ff @(posedge clk_base_i or negedge power_on_reset_n_i) begin
        if (!power_on_reset_n_i) begin
            fab_meta_q  <= 1'b0;
            fab_ok_q    <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            fab_meta_q  <= fab_reset_n_i;
            fab_ok_q    <= fab_meta_q;
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk_base_i or negedge power_on_reset_n_i) begin
        if (!power_on_reset_n_i) begin
            state_q     <= ST_HOLD;
            ch_q        <= '0;
            dly_q       <= '0;
            tmo_q       <= '0;
            lock_cnt_q  <= '0;
            rst_n_q     <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            err_ch_q    <= '0;
            stretch_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            dly_q       <= dly_d;
            tmo_q       <= tmo_d;
            lock_cnt_q  <= lock_cnt_d;
            rst_n_q     <= rst_n_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            err_ch_q    <= err_ch_d;
            stretch_q   <= stretch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        dly_d       = dly_q;
        tmo_d       = tmo_q;
        lock_cnt_d  = lock_cnt_q;
        rst_n_d     = rst_n_q;
        init_done_d = 1'b0;
        err_d       = err_q;
        err_ch_d    = err_ch_q;
        stretch_d   = stretch_q;
        step_ch     = 1'b0;

        unique case (state_q)
            ST_HOLD: begin
                rst_n_d = '0;
                err_d   = 1'b0;
                if (fab_ok_q) begin
                    state_d    = ST_LOCK_WAIT;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCK_WAIT: begin
                if (!lock_s_q) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d = ST_RELEASE;
                    ch_d    = '0;
                    dly_d   = '0;
                end else begin
                    lock_cnt_d = sat_inc(lock_cnt_q);
                end
            end
            ST_RELEASE: begin
                if (dly_q == DLY_LAST) begin
                    rst_n_d[ch_q] = 1'b1;
                    if (READY_MASK[ch_q]) begin
                        state_d = ST_READY_WAIT;
                        tmo_d   = '0;
                    end else begin
                        step_ch = 1'b1;
                    end
                end else begin
                    dly_d = sat_inc(dly_q);
                end
            end
            ST_READY_WAIT: begin
                if (seq_if.ch_ready[ch_q]) begin
                    step_ch = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    state_d  = ST_ERROR;
                    rst_n_d  = '0;
                    err_d    = 1'b1;
                    err_ch_d = 4'(ch_q);
                end else begin
                    tmo_d = sat_inc(tmo_q);
                end
            end
            ST_DONE: begin
                init_done_d = 1'b1;
                // Soft reset holds a channel low while requested, then for STRETCH_LD more cycles
                for (int k = 0; k < N_CH; k++) begin
                    if (seq_if.soft_reset[k]) begin
                        rst_n_d[k]   = 1'b0;
                        stretch_d[k] = STRETCH_LD;
                    end else if (stretch_q[k] != '0) begin
                        stretch_d[k] = stretch_q[k] - 1'b1;
                    end else begin
                        rst_n_d[k] = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                rst_n_d = '0;
                err_d   = 1'b1;
            end
            default: state_d = ST_HOLD;
        endcase

        if (step_ch) begin
            if (ch_q == CH_LAST) begin
                state_d = ST_DONE;
            end else begin
                ch_d    = ch_q + 1'b1;
                dly_d   = '0;
                state_d = ST_RELEASE;
            end
        end

        // Fabric reset beats lock loss; lock loss is ignored outside the sequencing states
        if (!fab_ok_q) begin
            state_d     = ST_HOLD;
            rst_n_d     = '0;
            init_done_d = 1'b0;
            err_d       = 1'b0;
            stretch_d   = '0;
        end else if (!lock_s_q && (state_q inside {ST_RELEASE, ST_READY_WAIT, ST_DONE})) begin
            state_d     = ST_LOCK_WAIT;
            lock_cnt_d  = '0;
            rst_n_d     = '0;
            init_done_d = 1'b0;
            stretch_d   = '0;
        end
    end

    assign seq_if.reset_n_out = rst_n_q;
    assign seq_if.init_done   = init_done_q;
    assign seq_if.err         = err_q;
    assign seq_if.err_ch      = err_ch_q;
    assign seq_if.seq_state   = state_q;
endmodule

// File: tb/tb_reset_sequencer_nch.sv
// Bench for reset_sequencer_nch: pin timelines per scenario, expected outputs
// derived from an event schedule (release times, ready edge, timeout edge).
module tb_reset_sequencer_nch;
    localparam int unsigned N_CH          = 4;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned REL_DELAY     = 8;
    localparam int unsigned LOCK_FILT     = 4;
    localparam int unsigned READY_TIMEOUT = 32;
    localparam logic [3:0]  READY_MASK    = 4'b0010;
    localparam int          NMAX          = 400;
    localparam int          NEVER         = 1_000_000;

    logic clk = 1'b0;
    logic rst_n, fab_n, lock;

    reset_sequencer_nch_if #(.N_CH(N_CH)) seq_bus ();

    reset_sequencer_nch #(
        .N_CH(N_CH), .CNT_W(CNT_W), .REL_DELAY(REL_DELAY), .LOCK_FILT(LOCK_FILT),
        .READY_TIMEOUT(READY_TIMEOUT), .READY_MASK(READY_MASK)
    ) dut (
        .clk_base_i(clk),
        .power_on_reset_n_i(rst_n),
        .fab_reset_n_i(fab_n),
        .pll_lock_i(lock),
        .seq_if(seq_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_edge = 0;

    // pin value presented before edge n
    logic       fab_p   [0:NMAX];
    logic       lock_p  [0:NMAX];
    logic [3:0] ready_p [0:NMAX];
    logic [3:0] soft_p  [0:NMAX];
    // expected outputs after edge n
    logic [3:0] e_rst   [0:NMAX];
    logic       e_done  [0:NMAX];
    logic       e_err   [0:NMAX];
    logic [3:0] e_errch [0:NMAX];
    logic [2:0] e_state [0:NMAX];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, cur_edge, got, exp);
        end
    endtask

    function automatic logic fab_at(input int n);
        return (n >= 3) ? fab_p[n-2] : 1'b0;
    endfunction

    function automatic logic lock_at(input int n);
        return (n >= 3) ? lock_p[n-2] : 1'b0;
    endfunction

    // Expected behaviour as an event schedule: on lock qualification, compute every
    // release edge, ready edge and timeout edge, then read outputs off that schedule.
    task automatic build_model(input int n_last);
        int mode;               // 0 hold, 1 lock wait, 2 sequencing, 3 error
        int run, t, t_err, t_done, err_k, cnt;
        int rel[N_CH];
        int rdy[N_CH];
        int soft_hi[N_CH];
        logic [3:0] mask;
        logic [3:0] errch_m;
        logic found;
        mask = READY_MASK;
        errch_m = '0;
        mode = 0; run = 0; t_err = NEVER; t_done = NEVER; err_k = 0;
        for (int k = 0; k < N_CH; k++) begin rel[k] = NEVER; rdy[k] = NEVER; soft_hi[k] = 0; end
        for (int n = 1; n <= n_last; n++) begin
            e_rst[n] = '0; e_done[n] = 1'b0; e_err[n] = 1'b0; e_state[n] = 3'd0;
            if (!fab_at(n)) begin
                mode = 0;
            end else if (mode == 0) begin
                mode = 1; run = 0; e_state[n] = 3'd1;
            end else if (mode == 1) begin
                run = lock_at(n) ? run + 1 : 0;
                e_state[n] = 3'd1;
                if (run == LOCK_FILT) begin
                    mode = 2; e_state[n] = 3'd2;
                    t = n; t_err = NEVER;
                    for (int k = 0; k < N_CH; k++) begin rel[k] = NEVER; rdy[k] = NEVER; soft_hi[k] = 0; end
                    for (int k = 0; k < N_CH; k++) begin
                        if (t_err == NEVER) begin
                            rel[k] = t + REL_DELAY;
                            t = rel[k];
                            if (mask[k]) begin
                                found = 1'b0;
                                for (int m = t + 1; m <= t + READY_TIMEOUT; m++)
                                    if (!found && m <= NMAX && ready_p[m][k]) begin found = 1'b1; rdy[k] = m; end
                                if (found) t = rdy[k];
                                else begin t_err = t + READY_TIMEOUT; err_k = k; end
                            end
                        end
                    end
                    t_done = (t_err == NEVER) ? t : NEVER;
                end
            end else if (mode == 2) begin
                if (!lock_at(n)) begin
                    mode = 1; run = 0; e_state[n] = 3'd1;
                end else if (n == t_err) begin
                    mode = 3; e_err[n] = 1'b1; e_state[n] = 3'd5; errch_m = 4'(err_k);
                end else if (n >= t_done) begin
                    e_state[n] = 3'd4;
                    e_done[n] = (n > t_done);
                    for (int k = 0; k < N_CH; k++) begin
                        if (n > t_done && soft_p[n][k]) soft_hi[k] = n + REL_DELAY + 1;
                        e_rst[n][k] = (n >= soft_hi[k]);
                    end
                end else begin
                    cnt = 0;
                    for (int k = 0; k < N_CH; k++) begin
                        e_rst[n][k] = (rel[k] <= n);
                        if (rel[k] <= n) cnt++;
                    end
                    e_state[n] = (cnt > 0 && mask[cnt-1] && rdy[cnt-1] > n) ? 3'd3 : 3'd2;
                end
            end else begin
                e_err[n] = 1'b1; e_state[n] = 3'd5;
            end
            e_errch[n] = errch_m;
        end
    endtask

    task automatic clear_pins(input int s);
        for (int n = 0; n <= NMAX; n++) begin
            fab_p[n] = (n >= s); lock_p[n] = 1'b1; ready_p[n] = '0; soft_p[n] = '0;
        end
    endtask

    task automatic ready_from(input int r);
        for (int n = r; n <= NMAX; n++) ready_p[n][1] = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_rst"},   32'(seq_bus.reset_n_out), 32'd0);
        check_val({tag, "_done"},  32'(seq_bus.init_done),   32'd0);
        check_val({tag, "_err"},   32'(seq_bus.err),         32'd0);
        check_val({tag, "_errch"}, 32'(seq_bus.err_ch),      32'd0);
        check_val({tag, "_state"}, 32'(seq_bus.seq_state),   32'd0);
    endtask

    task automatic run_scenario(input int n_last);
        rst_n = 1'b0; fab_n = 1'b0; lock = 1'b0;
        seq_bus.soft_reset = '0; seq_bus.ch_ready = '0;
        cur_edge = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        build_model(n_last);
        rst_n = 1'b1;
        for (int n = 1; n <= n_last; n++) begin
            fab_n = fab_p[n]; lock = lock_p[n];
            seq_bus.ch_ready = ready_p[n]; seq_bus.soft_reset = soft_p[n];
            cur_edge = n;
            @(posedge clk);
            #1;
            check_val("rst_n_out", 32'(seq_bus.reset_n_out), 32'(e_rst[n]));
            check_val("init_done", 32'(seq_bus.init_done),   32'(e_done[n]));
            check_val("err",       32'(seq_bus.err),         32'(e_err[n]));
            check_val("err_ch",    32'(seq_bus.err_ch),      32'(e_errch[n]));
            check_val("seq_state", 32'(seq_bus.seq_state),   32'(e_state[n]));
        end
        // asynchronous reset mid-cycle, checked before the next clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
    endtask

    initial begin
        int s, g, w, p;
        logic [3:0] noise;
        rst_n = 1'b0; fab_n = 1'b0; lock = 1'b0;
        seq_bus.soft_reset = '0; seq_bus.ch_ready = '0;

        // nominal: ch1 ready 5 cycles after its release
        clear_pins(1); ready_from(28);
        run_scenario(80);
        // simultaneous soft resets in DONE
        clear_pins(1); ready_from(28);
        for (int n = 60; n <= 62; n++) soft_p[n][2] = 1'b1;
        for (int n = 60; n <= 61; n++) soft_p[n][0] = 1'b1;
        run_scenario(90);
        // one-cycle lock glitch during filtering
        clear_pins(1); ready_from(28); lock_p[4] = 1'b0;
        run_scenario(80);
        // ready timeout, then fabric reset pulse recovers
        clear_pins(1);
        fab_p[65] = 1'b0; fab_p[66] = 1'b0;
        ready_from(70);
        run_scenario(160);
        // lock loss while ch2 is delaying
        clear_pins(1); ready_from(28); lock_p[31] = 1'b0;
        run_scenario(120);
        // stop inside READY_WAIT; async reset follows
        clear_pins(1);
        run_scenario(35);

        for (int it = 0; it < 10; it++) begin
            s = int'($urandom_range(1, 4));
            clear_pins(s);
            g = int'($urandom_range(0, 2));
            for (int i = 0; i < g; i++) begin
                p = int'($urandom_range(5, 120)); w = int'($urandom_range(1, 3));
                for (int n = p; n < p + w; n++) lock_p[n] = 1'b0;
            end
            for (int n = 0; n <= NMAX; n++) begin
                noise = 4'($urandom_range(0, 15));
                ready_p[n] = noise & ~READY_MASK;
            end
            ready_from(s + 22 + int'($urandom_range(1, 40)));
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    p = int'($urandom_range(70, 200)); w = int'($urandom_range(1, 4));
                    for (int n = p; n < p + w; n++) soft_p[n][k] = 1'b1;
                end
            end
            if ($urandom_range(0, 9) < 3) begin
                p = int'($urandom_range(100, 220)); w = int'($urandom_range(1, 3));
                for (int n = p; n < p + w; n++) fab_p[n] = 1'b0;
            end
            run_scenario(260);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
